// File: rtl/mips_writeback_queue_if.sv
// Write-back queue bus: the two producer handshakes, the register-file write port
// and the two forwarded read ports, bundled for the queue and whatever drives it.
interface mips_writeback_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
  logic              wb_idle;

  modport slave (
    input  mem_valid, mem_reg, mem_data,
    input  alu_valid, alu_reg, alu_data,
    input  read_reg1, read_reg2, rf_data1, rf_data2,
    output mem_ready, alu_ready,
    output write_reg, write_data, reg_write,
    output fwd_data1, fwd_data2, wb_idle
  );

  modport master (
    output mem_valid, mem_reg, mem_data,
    output alu_valid, alu_reg, alu_data,
    output read_reg1, read_reg2, rf_data1, rf_data2,
    input  mem_ready, alu_ready,
    input  write_reg, write_data, reg_write,
    input  fwd_data1, fwd_data2, wb_idle
  );
endinterface

// File: rtl/mips_writeback_queue.sv
// Write-back FIFO in front of the register file: merges load and ALU results,
// drains one per cycle into a registered write port and forwards pending writes.
module mips_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic              r_reg_write;

  logic [CNT_W-1:0]  w_free;
  logic              w_mem_acc, w_alu_acc;
  logic              w_mem_push, w_alu_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_alu_slot;
  logic [ADDR_W-1:0] w_rd  [2];
  logic [DATA_W-1:0] w_rf  [2];
  logic [DATA_W-1:0] w_fwd [2];
  logic              w_hit [2];
  logic [DATA_W-1:0] w_hit_val [2];

  // Free space comes from the registered count only; a pop this cycle does not help.
  assign w_free        = DEPTH_C - r_count;
  assign bus.mem_ready = (w_free != '0);
  assign bus.alu_ready = bus.mem_valid ? (w_free >= CNT_W'(2)) : (w_free != '0);

  assign w_mem_acc  = bus.mem_valid & bus.mem_ready;
  assign w_alu_acc  = bus.alu_valid & bus.alu_ready;
  assign w_mem_push = w_mem_acc & (bus.mem_reg != '0);
  assign w_alu_push = w_alu_acc & (bus.alu_reg != '0);
  assign w_pop      = (r_count != '0);
  assign w_alu_slot = r_wptr + PTR_W'(w_mem_push);

  // Storage is never reset; validity is defined purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_addr[r_wptr] <= bus.mem_reg;
      r_data[r_wptr] <= bus.mem_data;
    end
    if (w_alu_push) begin
      r_addr[w_alu_slot] <= bus.alu_reg;
      r_data[w_alu_slot] <= bus.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(w_mem_push) + PTR_W'(w_alu_push);
      r_count <= r_count + CNT_W'(w_mem_push) + CNT_W'(w_alu_push) - CNT_W'(w_pop);
      if (w_pop) begin
        r_write_reg  <= r_addr[r_rptr];
        r_write_data <= r_data[r_rptr];
        r_reg_write  <= 1'b1;
        r_rptr       <= r_rptr + PTR_W'(1);
      end else begin
        r_reg_write  <= 1'b0;
      end
    end
  end

  assign bus.write_reg  = r_write_reg;
  assign bus.write_data = r_write_data;
  assign bus.reg_write  = r_reg_write;
  assign bus.wb_idle    = (r_count == '0) && !r_reg_write;

  assign w_rd[0] = bus.read_reg1;
  assign w_rd[1] = bus.read_reg2;
  assign w_rf[0] = bus.rf_data1;
  assign w_rf[1] = bus.rf_data2;

  // Scan oldest to youngest so the last match is the youngest pending write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_hit[p]     = 1'b0;
      w_hit_val[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < r_count) && (r_addr[r_rptr + PTR_W'(i)] == w_rd[p])) begin
          w_hit[p]     = 1'b1;
          w_hit_val[p] = r_data[r_rptr + PTR_W'(i)];
        end
      end
      if (w_rd[p] == '0)
        w_fwd[p] = w_rf[p];
      else if (w_hit[p])
        w_fwd[p] = w_hit_val[p];
      else if (r_reg_write && (r_write_reg == w_rd[p]))
        w_fwd[p] = r_write_data;
      else
        w_fwd[p] = w_rf[p];
    end
  end

  assign bus.fwd_data1 = w_fwd[0];
  assign bus.fwd_data2 = w_fwd[1];
endmodule

// File: tb/tb_mips_writeback_queue.sv
// Directed bench for mips_writeback_queue with a small register-file model
// that absorbs the queue's writes and supplies rf_data.
module tb_mips_writeback_queue;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mips_writeback_queue_if #(.DATA_W(32), .ADDR_W(3)) bus ();

  mips_writeback_queue #(.DATA_W(32), .ADDR_W(3), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: register 0 is read-only, others start at A000_000i.
  logic [31:0] rf [8];
  logic        rf_loaded = 1'b0;
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 8; i++) rf[i] <= 32'hA000_0000 + 32'(i);
      rf_loaded <= 1'b1;
    end else if (bus.reg_write && bus.write_reg != 3'd0) begin
      rf[bus.write_reg] <= bus.write_data;
    end
  end
  assign bus.rf_data1 = rf[bus.read_reg1];
  assign bus.rf_data2 = rf[bus.read_reg2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.mem_valid = 1'b0; bus.mem_reg = 3'd0; bus.mem_data = 32'd0;
    bus.alu_valid = 1'b0; bus.alu_reg = 3'd0; bus.alu_data = 32'd0;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.read_reg1 = 3'd0; bus.read_reg2 = 3'd0;
    rst_n = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_reg = 3'd4; bus.mem_data = 32'h0000_1234;
    tick(); tick();
    checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("FAIL reset_reg_write got=%b exp=0", bus.reg_write); end
    checks++; if (bus.wb_idle !== 1'b1) begin failures++; $display("FAIL reset_wb_idle got=%b exp=1", bus.wb_idle); end
    bus.mem_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("FAIL release_reg_write got=%b exp=0", bus.reg_write); end
    tick();
    checks++; if (bus.reg_write !== 1'b0 || bus.wb_idle !== 1'b1) begin failures++; $display("FAIL release_quiet got rw=%b idle=%b exp rw=0 idle=1", bus.reg_write, bus.wb_idle); end
    $display("txn reset: held with mem_valid=1 reg 4, released");
  endtask

  task automatic test_single_alu;
    bus.read_reg1 = 3'd5;
    bus.alu_valid = 1'b1; bus.alu_reg = 3'd5; bus.alu_data = 32'hFFFF_FFFE;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL single_alu_ready got=%b exp=1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("FAIL single_rw_edge1 got=%b exp=0", bus.reg_write); end
    checks++; if (bus.fwd_data1 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL single_fwd_queued got=%h exp=fffffffe", bus.fwd_data1); end
    tick();
    checks++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 3'd5 || bus.write_data !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL single_write got rw=%b reg=%0d data=%h exp rw=1 reg=5 data=fffffffe", bus.reg_write, bus.write_reg, bus.write_data); end
    checks++; if (bus.fwd_data1 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL single_fwd_inflight got=%h exp=fffffffe", bus.fwd_data1); end
    tick();
    checks++; if (bus.reg_write !== 1'b0 || bus.wb_idle !== 1'b1) begin failures++; $display("FAIL single_idle got rw=%b idle=%b exp rw=0 idle=1", bus.reg_write, bus.wb_idle); end
    checks++; if (bus.fwd_data1 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL single_fwd_rf got=%h exp=fffffffe", bus.fwd_data1); end
    $display("txn alu push reg 5 data fffffffe");
  endtask

  task automatic test_same_cycle;
    bus.read_reg2 = 3'd7;
    bus.mem_valid = 1'b1; bus.mem_reg = 3'd7; bus.mem_data = 32'h0000_0011;
    bus.alu_valid = 1'b1; bus.alu_reg = 3'd7; bus.alu_data = 32'h0000_0022;
    #1;
    checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin failures++; $display("FAIL both_ready got mem=%b alu=%b exp 1 1", bus.mem_ready, bus.alu_ready); end
    tick();
    idle_inputs();
    checks++; if (bus.fwd_data2 !== 32'h22) begin failures++; $display("FAIL both_fwd_q got=%h exp=22", bus.fwd_data2); end
    tick();
    checks++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 3'd7 || bus.write_data !== 32'h11) begin
      failures++; $display("FAIL both_first got rw=%b reg=%0d data=%h exp rw=1 reg=7 data=11", bus.reg_write, bus.write_reg, bus.write_data); end
    checks++; if (bus.fwd_data2 !== 32'h22) begin failures++; $display("FAIL both_fwd_mid got=%h exp=22", bus.fwd_data2); end
    tick();
    checks++; if (bus.reg_write !== 1'b1 || bus.write_data !== 32'h22) begin
      failures++; $display("FAIL both_second got rw=%b data=%h exp rw=1 data=22", bus.reg_write, bus.write_data); end
    checks++; if (bus.fwd_data2 !== 32'h22) begin failures++; $display("FAIL both_fwd_late got=%h exp=22", bus.fwd_data2); end
    tick();
    checks++; if (rf[7] !== 32'h22 || bus.fwd_data2 !== 32'h22) begin failures++; $display("FAIL both_final got rf=%h fwd=%h exp 22", rf[7], bus.fwd_data2); end
    $display("txn mem+alu reg 7 data 11 then 22");
  endtask

  task automatic test_fill;
    bus.read_reg2 = 3'd6;
    bus.mem_valid = 1'b1; bus.mem_reg = 3'd1; bus.mem_data = 32'h101;
    bus.alu_valid = 1'b1; bus.alu_reg = 3'd2; bus.alu_data = 32'h202;
    tick();
    bus.mem_reg = 3'd3; bus.mem_data = 32'h303;
    bus.alu_reg = 3'd4; bus.alu_data = 32'h404;
    #1;
    checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin failures++; $display("FAIL fill_free2 got mem=%b alu=%b exp 1 1", bus.mem_ready, bus.alu_ready); end
    tick();
    bus.mem_reg = 3'd5; bus.mem_data = 32'h505;
    bus.alu_reg = 3'd6; bus.alu_data = 32'h606;
    #1;
    checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin failures++; $display("FAIL fill_free1 got mem=%b alu=%b exp 1 0", bus.mem_ready, bus.alu_ready); end
    checks++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 3'd1) begin failures++; $display("FAIL fill_w1 got rw=%b reg=%0d exp rw=1 reg=1", bus.reg_write, bus.write_reg); end
    tick();
    bus.mem_valid = 1'b0;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL fill_alu_alone got=%b exp=1", bus.alu_ready); end
    bus.alu_valid = 1'b0;
    checks++; if (bus.write_reg !== 3'd2) begin failures++; $display("FAIL fill_w2 got reg=%0d exp=2", bus.write_reg); end
    tick();
    checks++; if (bus.write_reg !== 3'd3 || bus.write_data !== 32'h303) begin failures++; $display("FAIL fill_w3 got reg=%0d data=%h exp 3 303", bus.write_reg, bus.write_data); end
    tick();
    checks++; if (bus.write_reg !== 3'd4 || bus.write_data !== 32'h404) begin failures++; $display("FAIL fill_w4 got reg=%0d data=%h exp 4 404", bus.write_reg, bus.write_data); end
    tick();
    checks++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 3'd5 || bus.write_data !== 32'h505) begin
      failures++; $display("FAIL fill_w5 got rw=%b reg=%0d data=%h exp 1 5 505", bus.reg_write, bus.write_reg, bus.write_data); end
    tick();
    checks++; if (bus.reg_write !== 1'b0 || bus.wb_idle !== 1'b1) begin failures++; $display("FAIL fill_drained got rw=%b idle=%b exp 0 1", bus.reg_write, bus.wb_idle); end
    checks++; if (bus.fwd_data2 !== 32'hA000_0006) begin failures++; $display("FAIL fill_rejected_alu got=%h exp=a0000006", bus.fwd_data2); end
    $display("txn fill: regs 1..5 written, alu reg 6 refused at free=1");
  endtask

  task automatic test_reg0;
    bus.read_reg1 = 3'd0;
    bus.alu_valid = 1'b1; bus.alu_reg = 3'd0; bus.alu_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL reg0_ready got=%b exp=1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.wb_idle !== 1'b1 || bus.fwd_data1 !== 32'hA000_0000) begin
      failures++; $display("FAIL reg0_discard got idle=%b fwd=%h exp 1 a0000000", bus.wb_idle, bus.fwd_data1); end
    tick();
    checks++; if (bus.reg_write !== 1'b0) begin failures++; $display("FAIL reg0_no_write got=%b exp=0", bus.reg_write); end
    $display("txn alu push reg 0 data ffffffff");
  endtask

  task automatic test_reset_queued;
    bus.read_reg1 = 3'd3;
    bus.mem_valid = 1'b1; bus.mem_reg = 3'd1; bus.mem_data = 32'hC1;
    bus.alu_valid = 1'b1; bus.alu_reg = 3'd2; bus.alu_data = 32'hC2;
    tick();
    bus.mem_reg = 3'd3; bus.mem_data = 32'hC3;
    bus.alu_reg = 3'd4; bus.alu_data = 32'hC4;
    tick();
    idle_inputs();
    checks++; if (bus.fwd_data1 !== 32'hC3) begin failures++; $display("FAIL rq_fwd_before got=%h exp=c3", bus.fwd_data1); end
    rst_n = 1'b0;
    tick();
    checks++; if (bus.reg_write !== 1'b0 || bus.wb_idle !== 1'b1) begin failures++; $display("FAIL rq_reset got rw=%b idle=%b exp 0 1", bus.reg_write, bus.wb_idle); end
    checks++; if (bus.fwd_data1 !== 32'h303) begin failures++; $display("FAIL rq_fwd_after got=%h exp=303", bus.fwd_data1); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.reg_write !== 1'b0 || bus.wb_idle !== 1'b1) begin failures++; $display("FAIL rq_release got rw=%b idle=%b exp 0 1", bus.reg_write, bus.wb_idle); end
    $display("txn reset with 3 entries queued");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle_inputs();
    bus.read_reg1 = 3'd0;
    bus.read_reg2 = 3'd0;
    test_reset();
    test_single_alu();
    test_same_cycle();
    test_fill();
    test_reg0();
    test_reset_queued();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
